ahb_lite_master: RTL
====================

// Module: ahb_lite_master
// PURPOSE
// - AHB-lite master bridge between the core load/store path and the peripheral bus (CLINT, UART, ...).
// - Turns single-word core requests into AHB-lite SINGLE/NONSEQ transfers.
// - Address and data phases are pipelined, so throughput is one transfer/cycle when the slave has zero wait states.
// - Handles HREADY wait states, two-cycle HRESP error responses and a stuck-slave timeout.
// PARAMETERS
// - TIMEOUT  default 255
//   - Consecutive HREADY=0 data-phase cycles before the transfer is abandoned.
//   - 0 disables the timeout.
// PORTS
// clk        in   1   system clock
// rst        in   1   synchronous reset, active-high
// req_valid  in   1   core request valid
// req_ready  out  1   request accepted when req_valid && req_ready at a clk edge
// req_write  in   1   1=write, 0=read
// req_addr   in   `WORD_WIDTH   byte address
// req_size   in   3   HSIZE code (byte/half/word)
// req_wdata  in   `WORD_WIDTH   write data, already lane-aligned
// rsp_valid  out  1   one-cycle completion pulse; no backpressure
// rsp_rdata  out  `WORD_WIDTH   HRDATA captured at completion (0 for writes)
// rsp_err    out  1   completion was an HRESP error or a timeout
// HADDR HWRITE HSIZE HBURST HTRANS HMASTLOCK HWDATA   out   AHB-lite master outputs, standard widths
// HRDATA HREADY HRESP                                 in    AHB-lite master inputs
// BEHAVIOUR
// - Reset (sync, rst=1) values:
//   - HTRANS=`HTRANS_IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, HBURST=3'b000, HMASTLOCK=0, HWDATA=0
//   - rsp_valid=0, rsp_rdata=0, rsp_err=0
//   - A and D stages empty; timeout counter=0.
//   - Reset mid-transfer drops all in-flight work with no response.
// - A-stage register: request on the bus address phase. HTRANS=NONSEQ while A is valid, else IDLE. HBURST is always SINGLE; HMASTLOCK is always 0.
// - D-stage register: transfer in data phase. HWDATA is registered from A's wdata when A moves to D, and is held stable until D completes.
// - Stage movement:
//   - adv = HREADY && !err1 at a clk edge.
//   - On adv, A moves to D (or D empties), and A loads the new request or empties.
//   - req_ready = !A_valid || adv (combinational).
// - Completion: D valid && HREADY=1 at an edge gives rsp_valid=1 in the next cycle.
//   - rsp_rdata = HRDATA for reads.
//   - rsp_err = (HRESP==`HRESP_ERROR).
// - Latency: request accepted at edge E0 gives NONSEQ in cycle 1, data phase in cycle 2, rsp_valid in cycle 3 (zero-wait slave).
// - Error, first cycle (err1): D valid, HREADY=0, HRESP=ERROR.
//   - Next cycle drives HTRANS=IDLE; the pending A request is held, not lost.
//   - A re-issues NONSEQ after the second error cycle (HREADY=1) completes D with rsp_err=1.
// - Timeout: the counter increments while D is valid and HREADY=0, and clears on any HREADY=1.
//   - When count == TIMEOUT: rsp_valid=1, rsp_err=1, rsp_rdata=0; D is cleared and HTRANS forced to IDLE for 1 cycle; A then re-issues.
//   - The counter saturates and never wraps.
// - Simultaneous: new request accept, A->D move and D completion may all occur at the same edge.
// - The address phase is never changed while HREADY=0 (AHB rule): HADDR/HWRITE/HSIZE/HTRANS are held.
// STRUCTURE
// - Shared defines header (already common): `WORD_WIDTH, `HTRANS_IDLE/NONSEQ, `HRESP_OKAY/ERROR, HBURST_SINGLE, HSIZE_BYTE/HALF/WORD codes.
// - One sub-module: ahb_master_timeout (saturating wait-state counter, enable/clear inputs, expire output).
// - A/D pipeline and error sequencing stay in this module.
// TESTING
// 1. Single write: addr 0x0200_0000, data 0x1, HREADY=1.
//    -> NONSEQ cycle 1, HWDATA=0x1 cycle 2, rsp_valid cycle 3, rsp_err=0.
// 2. Back-to-back reads of 4 addresses, zero-wait slave, HRDATA=addr.
//    -> req_ready stays 1; 4 rsp pulses on consecutive cycles with matching rdata.
// 3. Read with 3 wait states (HREADY=0 x3).
//    -> HADDR/HTRANS of the next request and HWDATA held stable; rsp arrives 3 cycles late.
// 4. Error response (HREADY=0/HRESP=ERROR, then HREADY=1/ERROR) with a queued second request.
//    -> HTRANS=IDLE in the 2nd error cycle; rsp_err=1; the second request is then issued and completes OK.
// 5. TIMEOUT=4, slave holds HREADY=0.
//    -> after 4 cycles rsp_valid=1, rsp_err=1, rdata=0; HTRANS=IDLE 1 cycle; the bridge accepts new requests.
// 6. Assert rst during the data phase of a write.
//    -> next cycle all outputs at reset values; no rsp_valid.

Source files
------------

// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-lite encodings and bus-sequencing state type for the master bridge.
package ahb_lite_master_pkg;

   localparam int          WORD_WIDTH    = 32;

   localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

   localparam logic        HRESP_OKAY    = 1'b0;
   localparam logic        HRESP_ERROR   = 1'b1;

   localparam logic [2:0]  HBURST_SINGLE = 3'b000;

   localparam logic [2:0]  HSIZE_BYTE    = 3'b000;
   localparam logic [2:0]  HSIZE_HALF    = 3'b001;
   localparam logic [2:0]  HSIZE_WORD    = 3'b010;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_ERR2    = 2'd1,
      ST_TO_IDLE = 2'd2
   } bus_state_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Core request/response handshake plus AHB-lite master signals.
interface ahb_lite_master_if;
   import ahb_lite_master_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [WORD_WIDTH-1:0] req_addr;
   logic [2:0]            req_size;
   logic [WORD_WIDTH-1:0] req_wdata;

   logic                  rsp_valid;
   logic [WORD_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   logic [WORD_WIDTH-1:0] HADDR;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [1:0]            HTRANS;
   logic                  HMASTLOCK;
   logic [WORD_WIDTH-1:0] HWDATA;
   logic [WORD_WIDTH-1:0] HRDATA;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      input  req_valid, req_write, req_addr, req_size, req_wdata,
      input  HRDATA, HREADY, HRESP,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_size, req_wdata,
      output HRDATA, HREADY, HRESP,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA
   );

endinterface

// File: rtl/ahb_master_timeout.sv
// Saturating wait-state counter; expire flags the edge at which the count reaches TIMEOUT.
module ahb_master_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count;

   // Count consecutive stalled cycles, hold at LIMIT, restart on any ready cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (TIMEOUT != 0) && en && (count == LIMIT - 1'b1);

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-lite master bridge: pipelined A (address) and D (data) stages with error and
// stuck-slave recovery.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUN     | normal pipelining; HTRANS follows A occupancy
//   ST_ERR2    | second HRESP error cycle; HTRANS=IDLE, A held for re-issue
//   ST_TO_IDLE | one idle cycle after a timeout abandons D; A held
module ahb_lite_master
   import ahb_lite_master_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   ahb_lite_master_if.master bus
);

   bus_state_t state, state_nxt;

   logic                  a_valid, a_write;
   logic [WORD_WIDTH-1:0] a_addr, a_wdata;
   logic [2:0]            a_size;
   logic                  d_valid, d_write;
   logic [WORD_WIDTH-1:0] hwdata_q;
   logic                  rsp_valid_q, rsp_err_q;
   logic [WORD_WIDTH-1:0] rsp_rdata_q;

   logic err1, adv, a_go, idle_slot, accept, expire, to_hit;

   assign idle_slot = (state != ST_RUN);
   assign err1      = d_valid && !bus.HREADY && (bus.HRESP == HRESP_ERROR);
   assign adv       = bus.HREADY && !err1;
   // A only advances if it was really presented on the bus this cycle.
   assign a_go      = adv && !idle_slot;
   assign accept    = bus.req_valid && bus.req_ready;
   assign to_hit    = d_valid && expire;

   assign bus.req_ready = !a_valid || a_go;

   ahb_master_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .en     (d_valid && !bus.HREADY),
      .clr    (bus.HREADY),
      .expire (expire)
   );

   // Bus-sequencing state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Next-state: timeout beats error handling; ERR2 ends on the ready error cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_RUN: begin
            if (to_hit)    state_nxt = ST_TO_IDLE;
            else if (err1) state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            if (to_hit)           state_nxt = ST_TO_IDLE;
            else if (bus.HREADY)  state_nxt = ST_RUN;
         end
         ST_TO_IDLE: state_nxt = ST_RUN;
         default:    state_nxt = ST_RUN;
      endcase
   end

   // A/D pipeline, write-data register and completion capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid     <= 1'b0;
         a_write     <= 1'b0;
         a_addr      <= '0;
         a_size      <= HSIZE_WORD;
         a_wdata     <= '0;
         d_valid     <= 1'b0;
         d_write     <= 1'b0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         if (to_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            d_valid     <= 1'b0;
         end else if (d_valid && bus.HREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= (bus.HRESP == HRESP_ERROR);
            rsp_rdata_q <= d_write ? '0 : bus.HRDATA;
            d_valid     <= 1'b0;
         end
         if (a_go) begin
            d_valid <= a_valid;
            d_write <= a_write;
            if (a_valid) hwdata_q <= a_wdata;
         end
         if (accept) begin
            a_valid <= 1'b1;
            a_write <= bus.req_write;
            a_addr  <= bus.req_addr;
            a_size  <= bus.req_size;
            a_wdata <= bus.req_wdata;
         end else if (a_go) begin
            a_valid <= 1'b0;
         end
      end
   end

   assign bus.HTRANS    = (a_valid && !idle_slot) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.HADDR     = a_addr;
   assign bus.HWRITE    = a_write;
   assign bus.HSIZE     = a_size;
   assign bus.HBURST    = HBURST_SINGLE;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.HWDATA    = hwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule
